// File: rtl/la_pkg.sv
// Shared state/mode types and register offsets for the logic-analyzer capture controller.
package la_pkg;

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        MOVE_TO_POSITION = 3'd1,
        IN_POSITION      = 3'd2,
        CAPTURING        = 3'd3,
        CAPTURED         = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SINGLE_SHOT = 2'd0,
        INCREMENTAL = 2'd1,
        IMMEDIATE   = 2'd2
    } trig_mode_t;

    localparam logic [15:0] REG_STATE     = 16'd0;
    localparam logic [15:0] REG_TRIG_MODE = 16'd1;
    localparam logic [15:0] REG_TRIG_LOC  = 16'd2;
    localparam logic [15:0] REG_START     = 16'd3;
    localparam logic [15:0] REG_STOP      = 16'd4;
    localparam logic [15:0] REG_READ_PTR  = 16'd5;
    localparam logic [15:0] REG_WRITE_PTR = 16'd6;
    localparam logic [15:0] REG_COUNT     = 16'd7;

endpackage

// File: rtl/la_bus_regfile.sv
// Daisy-chain bus slice: registered pass-through, 7-register window decode,
// config storage and rising-edge start/stop request pulses.
module la_bus_regfile
    import la_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       addr_i,
    input  logic [15:0]       wdata_i,
    input  logic [15:0]       rdata_i,
    input  logic              rw_i,
    input  logic              valid_i,
    output logic [15:0]       addr_o,
    output logic [15:0]       wdata_o,
    output logic [15:0]       rdata_o,
    output logic              rw_o,
    output logic              valid_o,
    input  state_t            state_i,
    input  logic [ADDR_W-1:0] read_ptr_i,
    input  logic [ADDR_W-1:0] write_ptr_i,
    output trig_mode_t        trig_mode_o,
    output logic [ADDR_W-1:0] trig_loc_o,
    output logic              start_o,
    output logic              stop_o
);

    localparam logic [15:0] BASE    = 16'(BASE_ADDR);
    localparam logic [15:0] LOC_MAX = 16'((1 << ADDR_W) - 1);

    logic [16:0]       diff;
    logic [15:0]       offset;
    logic              hit;
    logic              wr_hit;
    logic              cfg_open;
    logic [15:0]       reg_rdata;
    logic [15:0]       rdata_d;
    trig_mode_t        mode_q, mode_d;
    logic [ADDR_W-1:0] loc_q, loc_d;
    logic              req_start_q, req_start_d;
    logic              req_stop_q, req_stop_d;
    logic [15:0]       addr_q, wdata_q, rdata_q;
    logic              rw_q, valid_q;

    function automatic trig_mode_t decode_mode(input logic [1:0] v);
        return (v == 2'd3) ? SINGLE_SHOT : trig_mode_t'(v);
    endfunction

    function automatic logic [ADDR_W-1:0] sat_loc(input logic [15:0] v);
        return (v > LOC_MAX) ? LOC_MAX[ADDR_W-1:0] : v[ADDR_W-1:0];
    endfunction

    // 17-bit difference keeps the window check correct for any BASE_ADDR
    assign diff   = {1'b0, addr_i} - {1'b0, BASE};
    assign offset = diff[15:0];
    assign hit    = valid_i && !diff[16] && (offset < REG_COUNT);
    assign wr_hit = hit && rw_i;

    always_comb begin
        cfg_open    = (state_i == IDLE) || (state_i == CAPTURED);
        mode_d      = mode_q;
        loc_d       = loc_q;
        req_start_d = req_start_q;
        req_stop_d  = req_stop_q;
        start_o     = 1'b0;
        stop_o      = 1'b0;
        if (wr_hit) begin
            case (offset)
                REG_TRIG_MODE: if (cfg_open) mode_d = decode_mode(wdata_i[1:0]);
                REG_TRIG_LOC:  if (cfg_open) loc_d = sat_loc(wdata_i);
                REG_START: begin
                    start_o     = wdata_i[0] && !req_start_q;
                    req_start_d = wdata_i[0];
                end
                REG_STOP: begin
                    stop_o     = wdata_i[0] && !req_stop_q;
                    req_stop_d = wdata_i[0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        reg_rdata = 16'd0;
        case (offset)
            REG_STATE:     reg_rdata = {13'd0, state_i};
            REG_TRIG_MODE: reg_rdata = {14'd0, mode_q};
            REG_TRIG_LOC:  reg_rdata = 16'(loc_q);
            REG_START:     reg_rdata = {15'd0, req_start_q};
            REG_STOP:      reg_rdata = {15'd0, req_stop_q};
            REG_READ_PTR:  reg_rdata = 16'(read_ptr_i);
            REG_WRITE_PTR: reg_rdata = 16'(write_ptr_i);
            default:       reg_rdata = 16'd0;
        endcase
        rdata_d = (hit && !rw_i) ? reg_rdata : rdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rw_q        <= 1'b0;
            valid_q     <= 1'b0;
            mode_q      <= SINGLE_SHOT;
            loc_q       <= '0;
            req_start_q <= 1'b0;
            req_stop_q  <= 1'b0;
        end else begin
            addr_q      <= addr_i;
            wdata_q     <= wdata_i;
            rdata_q     <= rdata_d;
            rw_q        <= rw_i;
            valid_q     <= valid_i;
            mode_q      <= mode_d;
            loc_q       <= loc_d;
            req_start_q <= req_start_d;
            req_stop_q  <= req_stop_d;
        end
    end

    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign rdata_o     = rdata_q;
    assign rw_o        = rw_q;
    assign valid_o     = valid_q;
    assign trig_mode_o = mode_q;
    assign trig_loc_o  = loc_q;

endmodule

// File: rtl/la_capture_controller.sv
// Capture sequencer: single-shot with circular pre-trigger buffer, incremental
// and immediate captures, driving the sample-memory write port.
module la_capture_controller
    import la_pkg::*;
#(
    parameter int BASE_ADDR    = 0,
    parameter int SAMPLE_DEPTH = 1024,
    parameter int ADDR_W       = $clog2(SAMPLE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig_i,
    input  logic [15:0]       addr_i,
    input  logic [15:0]       wdata_i,
    input  logic [15:0]       rdata_i,
    input  logic              rw_i,
    input  logic              valid_i,
    output logic [15:0]       addr_o,
    output logic [15:0]       wdata_o,
    output logic [15:0]       rdata_o,
    output logic              rw_o,
    output logic              valid_o,
    output logic [2:0]        state_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic              bram_we_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [ADDR_W-1:0] wp_inc;
    trig_mode_t        mode;
    logic [ADDR_W-1:0] loc;
    logic              start, stop, we;

    la_bus_regfile #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_W    (ADDR_W)
    ) u_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_i     (rdata_i),
        .rw_i        (rw_i),
        .valid_i     (valid_i),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .rdata_o     (rdata_o),
        .rw_o        (rw_o),
        .valid_o     (valid_o),
        .state_i     (state_q),
        .read_ptr_i  (rp_q),
        .write_ptr_i (wp_q),
        .trig_mode_o (mode),
        .trig_loc_o  (loc),
        .start_o     (start),
        .stop_o      (stop)
    );

    assign wp_inc = wp_q + ADDR_W'(1);

    // Write enable follows the registered state only, so a stop takes effect the cycle after it
    always_comb begin
        we = 1'b0;
        case (state_q)
            MOVE_TO_POSITION, IN_POSITION: we = 1'b1;
            CAPTURING:                     we = (mode == INCREMENTAL) ? trig_i : 1'b1;
            default:                       we = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        if (stop) begin
            state_d = IDLE;
            wp_d    = '0;
            rp_d    = '0;
        end else begin
            case (state_q)
                IDLE, CAPTURED: begin
                    if (start) begin
                        wp_d = '0;
                        rp_d = '0;
                        if (mode != SINGLE_SHOT)
                            state_d = CAPTURING;
                        else if (loc != '0)
                            state_d = MOVE_TO_POSITION;
                        else
                            state_d = IN_POSITION;
                    end
                end
                MOVE_TO_POSITION: begin
                    wp_d = wp_inc;
                    if (wp_inc == loc)
                        state_d = IN_POSITION;
                end
                IN_POSITION: begin
                    // read_pointer holds on the trigger write so the oldest sample stays trigger_loc behind it
                    wp_d = wp_inc;
                    if (trig_i)
                        state_d = (wp_inc == rp_q) ? CAPTURED : CAPTURING;
                    else
                        rp_d = rp_q + ADDR_W'(1);
                end
                CAPTURING: begin
                    if (we) begin
                        wp_d = wp_inc;
                        if (wp_inc == rp_q)
                            state_d = CAPTURED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
        end
    end

    assign state_o     = state_q;
    assign bram_addr_o = wp_q;
    assign bram_we_o   = we;

endmodule

// File: tb/tb_la_capture_controller.sv
// Directed bench for la_capture_controller (SAMPLE_DEPTH=8): counter-based
// reference model checked every cycle, plus literal expectations.
module tb_la_capture_controller;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trig_i;
    logic [15:0]   addr_i, wdata_i, rdata_i;
    logic          rw_i, valid_i;
    logic [15:0]   addr_o, wdata_o, rdata_o;
    logic          rw_o, valid_o;
    logic [2:0]    state_o;
    logic [AW-1:0] bram_addr_o;
    logic          bram_we_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    la_capture_controller #(
        .BASE_ADDR    (0),
        .SAMPLE_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig_i      (trig_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_i     (rdata_i),
        .rw_i        (rw_i),
        .valid_i     (valid_i),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .rdata_o     (rdata_o),
        .rw_o        (rw_o),
        .valid_o     (valid_o),
        .state_o     (state_o),
        .bram_addr_o (bram_addr_o),
        .bram_we_o   (bram_we_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: state numbers, pointers and remaining-write counters
    int m_state, m_wp, m_rp, m_mode, m_loc, m_rs, m_rstop, m_pre, m_post;
    int m_off;
    bit m_hit, m_wr, m_st, m_sp, m_cfg;
    int m_wen;
    logic [15:0] e_addr, e_wdata, e_rdata;
    logic        e_rw, e_valid;

    function automatic int exp_we();
        if (m_state == 1 || m_state == 2) return 1;
        if (m_state == 3) return (m_mode == 1) ? int'(trig_i) : 1;
        return 0;
    endfunction

    function automatic logic [15:0] m_read(input int off);
        case (off)
            0: return 16'(m_state);
            1: return 16'(m_mode);
            2: return 16'(m_loc);
            3: return 16'(m_rs);
            4: return 16'(m_rstop);
            5: return 16'(m_rp);
            6: return 16'(m_wp);
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_wp = 0; m_rp = 0; m_mode = 0; m_loc = 0;
            m_rs = 0; m_rstop = 0; m_pre = 0; m_post = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0; e_rw = 1'b0; e_valid = 1'b0;
        end else begin
            m_hit = valid_i && (addr_i < 16'd7);
            m_off = int'(addr_i);
            e_addr = addr_i; e_wdata = wdata_i; e_rw = rw_i; e_valid = valid_i;
            e_rdata = (m_hit && !rw_i) ? m_read(m_off) : rdata_i;
            m_wr  = m_hit && rw_i;
            m_st  = m_wr && m_off == 3 && wdata_i[0] && m_rs == 0;
            m_sp  = m_wr && m_off == 4 && wdata_i[0] && m_rstop == 0;
            m_cfg = (m_state == 0 || m_state == 4);
            m_wen = exp_we();
            if (m_sp) begin
                m_state = 0; m_wp = 0; m_rp = 0;
            end else begin
                case (m_state)
                    0, 4: if (m_st) begin
                        m_wp = 0; m_rp = 0;
                        if (m_mode != 0) begin m_state = 3; m_post = DEPTH; end
                        else if (m_loc > 0) begin m_state = 1; m_pre = m_loc; end
                        else m_state = 2;
                    end
                    1: begin
                        m_wp = (m_wp + 1) % DEPTH;
                        m_pre--;
                        if (m_pre == 0) m_state = 2;
                    end
                    2: begin
                        m_wp = (m_wp + 1) % DEPTH;
                        if (trig_i) begin
                            m_post  = DEPTH - m_loc - 1;
                            m_state = (m_post == 0) ? 4 : 3;
                        end else m_rp = (m_rp + 1) % DEPTH;
                    end
                    3: if (m_wen != 0) begin
                        m_wp = (m_wp + 1) % DEPTH;
                        m_post--;
                        if (m_post == 0) m_state = 4;
                    end
                    default: ;
                endcase
            end
            if (m_wr && m_off == 1 && m_cfg) m_mode = (wdata_i[1:0] == 2'd3) ? 0 : int'(wdata_i[1:0]);
            if (m_wr && m_off == 2 && m_cfg) m_loc = (wdata_i > 16'd7) ? 7 : int'(wdata_i);
            if (m_wr && m_off == 3) m_rs = int'(wdata_i[0]);
            if (m_wr && m_off == 4) m_rstop = int'(wdata_i[0]);
        end
    end

    always @(negedge clk) begin
        chk("state_o", 32'(state_o), m_state);
        chk("bram_addr_o", 32'(bram_addr_o), m_wp);
        chk("bram_we_o", 32'(bram_we_o), exp_we());
        chk("addr_o", 32'(addr_o), 32'(e_addr));
        chk("wdata_o", 32'(wdata_o), 32'(e_wdata));
        chk("rdata_o", 32'(rdata_o), 32'(e_rdata));
        chk("rw_o", 32'(rw_o), 32'(e_rw));
        chk("valid_o", 32'(valid_o), 32'(e_valid));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        addr_i = a; wdata_i = d; rw_i = 1'b1; valid_i = 1'b1;
        tick();
        valid_i = 1'b0; rw_i = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
        addr_i = a; rw_i = 1'b0; valid_i = 1'b1;
        tick();
        d = rdata_o;
        valid_i = 1'b0;
    endtask

    task automatic wait_captured(input string nm);
        for (int i = 0; i < 40 && state_o != 3'd4; i++) tick();
        chk(nm, 32'(state_o), 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t, required < 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        logic [29:0] pat;
        int hits[8] = '{1, 4, 5, 9, 14, 20, 23, 28};

        rst_n = 1'b0; trig_i = 1'b0; addr_i = '0; wdata_i = '0;
        rdata_i = 16'hC3C3; rw_i = 1'b0; valid_i = 1'b0;
        #7;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_we", 32'(bram_we_o), 32'd0);
        chk("rst_rdata_o", 32'(rdata_o), 32'd0);
        #15 rst_n = 1'b1;
        tick();

        // Config writes in IDLE: saturation and mode 3 folding
        bus_wr(16'd2, 16'd20);
        bus_rd(16'd2, rd); chk("loc_sat", 32'(rd), 32'd7);
        bus_wr(16'd1, 16'd3);
        bus_rd(16'd1, rd); chk("mode3_as0", 32'(rd), 32'd0);

        // Single shot, trigger_loc=3, trigger sampled 10 cycles after start
        bus_wr(16'd2, 16'd3);
        bus_wr(16'd3, 16'd1);
        chk("ss_move", 32'(state_o), 32'd1);
        tick(); tick();
        chk("ss_move_3rd", 32'(state_o), 32'd1);
        tick();
        chk("ss_in_pos", 32'(state_o), 32'd2);
        repeat (6) tick();
        trig_i = 1'b1;
        chk("ss_trig_addr", 32'(bram_addr_o), 32'd1);
        tick();
        trig_i = 1'b0;
        chk("ss_capturing", 32'(state_o), 32'd3);
        wait_captured("ss_captured");
        bus_rd(16'd5, rd); chk("ss_read_ptr", 32'(rd), 32'd6);
        bus_rd(16'd6, rd); chk("ss_write_ptr", 32'(rd), 32'd6);

        // Immediate; mode write during capture must be ignored
        bus_wr(16'd1, 16'd2);
        bus_wr(16'd3, 16'd0);
        bus_wr(16'd3, 16'd1);
        chk("imm_capturing", 32'(state_o), 32'd3);
        bus_wr(16'd1, 16'd1);
        bus_rd(16'd1, rd); chk("mode_locked", 32'(rd), 32'd2);
        repeat (5) tick();
        chk("imm_7th", 32'(state_o), 32'd3);
        tick();
        chk("imm_captured", 32'(state_o), 32'd4);

        // Incremental: 8 scattered triggers over 30 cycles
        bus_wr(16'd1, 16'd1);
        bus_wr(16'd3, 16'd0);
        bus_wr(16'd3, 16'd1);
        pat = '0;
        foreach (hits[k]) pat[hits[k]] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            trig_i = pat[i];
            tick();
        end
        trig_i = 1'b0;
        chk("inc_captured", 32'(state_o), 32'd4);
        bus_rd(16'd5, rd); chk("inc_read_ptr", 32'(rd), 32'd0);
        bus_rd(16'd6, rd); chk("inc_write_ptr", 32'(rd), 32'd0);
        bus_rd(16'd0, rd); chk("state_readback", 32'(rd), 32'd4);

        // Out-of-window read passes rdata_i through
        rdata_i = 16'h1234;
        bus_rd(16'd9, rd);
        chk("passthru_rdata", 32'(rd), 32'h1234);
        chk("passthru_addr", 32'(addr_o), 32'd9);
        rdata_i = 16'hC3C3;

        // Stop during IN_POSITION, then a start without clearing request_start
        bus_wr(16'd1, 16'd0);
        bus_wr(16'd2, 16'd2);
        bus_wr(16'd3, 16'd0);
        bus_wr(16'd3, 16'd1);
        tick(); tick();
        chk("stop_in_pos", 32'(state_o), 32'd2);
        bus_wr(16'd4, 16'd1);
        chk("stop_idle", 32'(state_o), 32'd0);
        chk("stop_wp", 32'(bram_addr_o), 32'd0);
        chk("stop_we", 32'(bram_we_o), 32'd0);
        bus_wr(16'd3, 16'd1);
        chk("no_edge_start", 32'(state_o), 32'd0);
        tick();
        chk("no_edge_start2", 32'(state_o), 32'd0);

        // Asynchronous reset mid-capture
        bus_wr(16'd3, 16'd0);
        bus_wr(16'd1, 16'd2);
        bus_wr(16'd3, 16'd1);
        tick(); tick();
        chk("pre_rst_capturing", 32'(state_o), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_we", 32'(bram_we_o), 32'd0);
        chk("arst_wp", 32'(bram_addr_o), 32'd0);
        chk("arst_valid_o", 32'(valid_o), 32'd0);
        chk("arst_wdata_o", 32'(wdata_o), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        bus_rd(16'd1, rd); chk("arst_mode", 32'(rd), 32'd0);
        bus_rd(16'd3, rd); chk("arst_req_start", 32'(rd), 32'd0);
        bus_rd(16'd5, rd); chk("arst_read_ptr", 32'(rd), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
